spi_controller: RTL and testbench

SPI mode-0 controller that drives SCLK/CS/COPI and samples CIPO. It is the initiator for spi_peripheral: it feeds the OCR FPGA in system-level benches and serves as an on-chip master for bring-up. Bytes arrive on a valid/ready stream, with tx_last closing the frame. Each received byte comes back as rx_byte plus a 1-cycle rx_valid.

---
 rtl/spi_controller.sv | 161 ++++++++++++++++
 tb/tb_spi_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: valid/ready byte stream in, rx_byte/rx_valid out.
// Optional debug outputs enabled by defining SPI_CONTROLLER_DEBUG_EN.
module spi_controller #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCLK,
  output logic       COPI,
  output logic       CS,
  input  logic       CIPO
`ifdef SPI_CONTROLLER_DEBUG_EN
  ,
  output logic [2:0]  debug_state,
  output logic [3:0]  debug_bit_count,
  output logic [15:0] debug_frame_count
`endif
);

  localparam int MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_P  = (CLK_DIV > MAX_SH) ? CLK_DIV : MAX_SH;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SET_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HLD_LD = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    LOW       = 3'd2,
    HIGH      = 3'd3,
    WAIT_NEXT = 3'd4,
    HOLD      = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic          last;

  assign tx_ready = (state == IDLE) || (state == WAIT_NEXT);
  assign busy     = (state != IDLE);

  // Frame sequencer: CS framing, SCLK phases, shift registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      last     <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      SCLK     <= 1'b0;
      COPI     <= 1'b0;
      CS       <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_byte[6:0];
            last     <= tx_last;
            CS       <= 1'b0;
            COPI     <= tx_byte[7];
            bit_cnt  <= '0;
            cnt      <= SET_LD;
            state    <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (cnt == '0) begin
            SCLK     <= 1'b1;
            rx_shift <= {rx_shift[6:0], CIPO};
            cnt      <= DIV_LD;
            state    <= HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            SCLK <= 1'b0;
            if (bit_cnt != 3'd7) begin
              bit_cnt  <= bit_cnt + 1'b1;
              COPI     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              cnt      <= DIV_LD;
              state    <= LOW;
            end else begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
              cnt      <= HLD_LD;
              state    <= last ? HOLD : WAIT_NEXT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_NEXT: begin
          if (tx_valid) begin
            tx_shift <= tx_byte[6:0];
            last     <= tx_last;
            COPI     <= tx_byte[7];
            bit_cnt  <= '0;
            cnt      <= DIV_LD;
            state    <= LOW;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            CS    <= 1'b1;
            cnt   <= HLD_LD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CONTROLLER_DEBUG_EN
  // Registered debug view; frame count steps when CS rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debug_state       <= '0;
      debug_bit_count   <= '0;
      debug_frame_count <= '0;
    end else begin
      debug_state     <= state;
      debug_bit_count <= {1'b0, bit_cnt};
      if (state == HOLD && cnt == '0)
        debug_frame_count <= debug_frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed self-checking bench for spi_controller.
// Uses a CLK_DIV=4 instance and a CLK_DIV=8 instance with a peripheral model.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
  logic       SCLK, COPI, CS, CIPO;
  logic       loop_en = 1'b0;

  logic [7:0] tx_byte8 = '0;
  logic       tx_last8 = 1'b0;
  logic       tx_valid8 = 1'b0;
  logic       tx_ready8;
  logic [7:0] rx_byte8;
  logic       rx_valid8;
  logic       busy8;
  logic       SCLK8, COPI8, CS8;
  logic       p_cipo = 1'b1;

  int chk = 0;
  int err = 0;

  assign CIPO = loop_en ? COPI : 1'b0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4)) u_dut (
    .clk(clk), .rst(rst),
    .tx_byte(tx_byte), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .busy(busy), .SCLK(SCLK), .COPI(COPI),
    .CS(CS), .CIPO(CIPO)
  );

  spi_controller #(.CLK_DIV(8), .CS_SETUP(4), .CS_HOLD(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .tx_byte(tx_byte8), .tx_last(tx_last8),
    .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .rx_byte(rx_byte8), .rx_valid(rx_valid8),
    .busy(busy8), .SCLK(SCLK8), .COPI(COPI8),
    .CS(CS8), .CIPO(p_cipo)
  );

  // Monitor for the CLK_DIV=4 instance
  logic mon_clr = 1'b0;
  int cyc = 0;
  int rises, falls_cs, rises_cs, rx_cnt;
  int first_rise, rise_c, last_fall, cs_fall, cs_rise, idle_c;
  int hi_min, hi_max, lo_min, lo_max;
  logic [15:0] copi_cap;
  logic sclk_q = 0, cs_q = 1, busy_q = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      rises = 0; falls_cs = 0; rises_cs = 0; rx_cnt = 0;
      first_rise = -1; rise_c = -1; last_fall = -1;
      cs_fall = -1; cs_rise = -1; idle_c = -1;
      hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
      copi_cap = '0;
    end else begin
      if (SCLK && !sclk_q) begin
        rises++;
        copi_cap = {copi_cap[14:0], COPI};
        if (rises == 1) first_rise = cyc;
        if (last_fall >= 0) begin
          if (cyc - last_fall < lo_min) lo_min = cyc - last_fall;
          if (cyc - last_fall > lo_max) lo_max = cyc - last_fall;
        end
        rise_c = cyc;
      end
      if (!SCLK && sclk_q) begin
        if (cyc - rise_c < hi_min) hi_min = cyc - rise_c;
        if (cyc - rise_c > hi_max) hi_max = cyc - rise_c;
        last_fall = cyc;
      end
      if (!CS && cs_q) begin falls_cs++; cs_fall = cyc; end
      if (CS && !cs_q) begin rises_cs++; cs_rise = cyc; end
      if (!busy && busy_q) idle_c = cyc;
      if (rx_valid) rx_cnt++;
    end
    sclk_q = SCLK; cs_q = CS; busy_q = busy;
  end

  // Mode-0 peripheral model for the CLK_DIV=8 instance
  logic [7:0] p_tx = 8'hC3, p_rx = '0, p_last = '0;
  int p_bits = 0, p_bytes = 0, rx8_cnt = 0;
  logic s8_q = 0;
  always @(negedge clk) begin
    if (rx_valid8) rx8_cnt++;
    if (CS8) begin
      p_tx = 8'hC3; p_cipo = 1'b1; p_bits = 0;
    end else if (SCLK8 && !s8_q) begin
      p_rx = {p_rx[6:0], COPI8};
      p_bits++;
      if (p_bits == 8) begin p_bytes++; p_last = p_rx; end
    end else if (!SCLK8 && s8_q) begin
      p_tx = {p_tx[6:0], 1'b0};
      p_cipo = p_tx[7];
    end
    s8_q = SCLK8;
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    bit ok = 0;
    tx_byte = b; tx_last = l; tx_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (tx_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL send_accept: byte %h not accepted, required accept", b);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy && CS) begin ok = 1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL %s_idle: busy=%b CS=%b, required 0/1", nm, busy, CS);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk++;
    if ({CS, SCLK, COPI, rx_valid, busy, rx_byte} !== {5'b10000, 8'h00}) begin
      err++;
      $display("FAIL reset_outputs: CS%b SCLK%b COPI%b rxv%b busy%b rx%h, required 1 0 0 0 0 00",
               CS, SCLK, COPI, rx_valid, busy, rx_byte);
    end
    chk++;
    if (tx_ready !== 1'b1) begin
      err++;
      $display("FAIL reset_tx_ready: got %b required 1", tx_ready);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    loop_en = 1'b0;
    clear_mon();
    send(8'hA5, 1'b1);
    wait_idle("single");
    chk++;
    if (first_rise - cs_fall !== 4) begin
      err++;
      $display("FAIL setup_time: got %0d required 4", first_rise - cs_fall);
    end
    chk++;
    if (rises !== 8) begin
      err++;
      $display("FAIL sclk_rises: got %0d required 8", rises);
    end
    chk++;
    if (hi_min !== 4 || hi_max !== 4) begin
      err++;
      $display("FAIL high_width: got %0d..%0d required 4", hi_min, hi_max);
    end
    chk++;
    if (lo_min !== 4 || lo_max !== 4) begin
      err++;
      $display("FAIL low_width: got %0d..%0d required 4", lo_min, lo_max);
    end
    chk++;
    if (copi_cap[7:0] !== 8'hA5) begin
      err++;
      $display("FAIL copi_bits: got %h required a5", copi_cap[7:0]);
    end
    chk++;
    if (cs_rise - last_fall !== 4) begin
      err++;
      $display("FAIL hold_time: got %0d required 4", cs_rise - last_fall);
    end
    chk++;
    if (idle_c - cs_rise !== 4) begin
      err++;
      $display("FAIL gap_time: got %0d required 4", idle_c - cs_rise);
    end
    chk++;
    if (rx_cnt !== 1 || rx_byte !== 8'h00) begin
      err++;
      $display("FAIL single_rx: cnt %0d byte %h required 1 00", rx_cnt, rx_byte);
    end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    clear_mon();
    send(8'h3C, 1'b1);
    wait_idle("loop");
    chk++;
    if (rx_cnt !== 1 || rx_byte !== 8'h3C) begin
      err++;
      $display("FAIL loop_rx: cnt %0d byte %h required 1 3c", rx_cnt, rx_byte);
    end
    chk++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL loop_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    loop_en = 1'b1;
    clear_mon();
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    wait_idle("burst");
    chk++;
    if (falls_cs !== 1 || rises_cs !== 1) begin
      err++;
      $display("FAIL burst_cs: falls %0d rises %0d required 1 1", falls_cs, rises_cs);
    end
    chk++;
    if (rises !== 16 || copi_cap !== 16'h1234) begin
      err++;
      $display("FAIL burst_bits: rises %0d copi %h required 16 1234", rises, copi_cap);
    end
    chk++;
    if (rx_cnt !== 2 || rx_byte !== 8'h34) begin
      err++;
      $display("FAIL burst_rx: cnt %0d byte %h required 2 34", rx_cnt, rx_byte);
    end
    chk++;
    if (cs_rise <= last_fall) begin
      err++;
      $display("FAIL burst_cs_order: cs_rise %0d last_fall %0d required later", cs_rise, last_fall);
    end
  endtask

  task automatic test_wait_next();
    int bad = 0;
    bit ok = 0;
    loop_en = 1'b1;
    clear_mon();
    send(8'h6E, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if (tx_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL wait_reach: tx_ready %b required 1", tx_ready);
    end
    for (int i = 0; i < 50; i++) begin
      if (SCLK !== 1'b0 || CS !== 1'b0 || tx_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    chk++;
    if (bad !== 0) begin
      err++;
      $display("FAIL wait_hold: %0d bad cycles, required 0", bad);
    end
    send(8'h91, 1'b1);
    wait_idle("wait");
    chk++;
    if (rx_cnt !== 2 || rx_byte !== 8'h91 || copi_cap !== 16'h6E91) begin
      err++;
      $display("FAIL wait_rx: cnt %0d byte %h copi %h required 2 91 6e91",
               rx_cnt, rx_byte, copi_cap);
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    int rc;
    loop_en = 1'b1;
    clear_mon();
    send(8'hFF, 1'b1);
    for (int i = 0; i < 500; i++) begin
      if (rises >= 3) begin ok = 1; break; end
      @(negedge clk);
    end
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL mid_reach: rises %0d required 3", rises);
    end
    rst = 1'b0;
    #1;
    chk++;
    if (CS !== 1'b1 || SCLK !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0) begin
      err++;
      $display("FAIL mid_reset: CS%b SCLK%b busy%b rxv%b required 1 0 0 0",
               CS, SCLK, busy, rx_valid);
    end
    rc = rx_cnt;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk++;
    if (rx_cnt !== rc || rx_byte !== 8'h00) begin
      err++;
      $display("FAIL mid_no_rx: cnt %0d byte %h required %0d 00", rx_cnt, rx_byte, rc);
    end
    clear_mon();
    send(8'h81, 1'b1);
    wait_idle("after_rst");
    chk++;
    if (rx_cnt !== 1 || rx_byte !== 8'h81 || copi_cap[7:0] !== 8'h81) begin
      err++;
      $display("FAIL after_rst_rx: cnt %0d byte %h copi %h required 1 81 81",
               rx_cnt, rx_byte, copi_cap[7:0]);
    end
  endtask

  task automatic test_peripheral();
    bit ok = 0;
    @(negedge clk);
    tx_byte8 = 8'h5A; tx_last8 = 1'b1; tx_valid8 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (tx_ready8) begin @(negedge clk); ok = 1; break; end
      @(negedge clk);
    end
    tx_valid8 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy8 && ok) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk++;
    if (!ok || busy8 !== 1'b0) begin
      err++;
      $display("FAIL periph_done: accepted %b busy %b required 1 0", ok, busy8);
    end
    chk++;
    if (p_bytes !== 1 || p_last !== 8'h5A) begin
      err++;
      $display("FAIL periph_rx: bytes %0d byte %h required 1 5a", p_bytes, p_last);
    end
    chk++;
    if (rx8_cnt !== 1 || rx_byte8 !== 8'hC3) begin
      err++;
      $display("FAIL ctrl_rx8: cnt %0d byte %h required 1 c3", rx8_cnt, rx_byte8);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_loopback();
    test_back_to_back();
    test_wait_next();
    test_reset_mid();
    test_peripheral();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
